call_request_conditioner: RTL and testbench

//  Upstream front end for input_manager/controller: synchronises and debounces

---
 rtl/elevator_pkg.sv | 37 +++
 rtl/button_debouncer.sv | 45 ++++
 rtl/call_request_conditioner.sv | 249 ++++++++++++++++++++++++
 tb/tb_call_request_conditioner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants and request record for the elevator call front end.
// Consumed by call_request_conditioner and button_debouncer.
package elevator_pkg;

    localparam int FLOOR_W   = 3;
    localparam int TOP_FLOOR = 7;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic CALL_IN   = 1'b1;
    localparam logic CALL_HALL = 1'b0;

    typedef struct packed {
        logic [FLOOR_W-1:0] floor;
        logic               in_out;
        logic               dir;
    } req_t;

    // Integer arguments keep the range checks free of width-limited compares.
    function automatic logic call_legal(
        input int   floor,
        input int   top,
        input logic in_out,
        input logic dir
    );
        logic ok;
        ok = 1'b1;
        if (floor > top)
            ok = 1'b0;
        if (in_out == CALL_HALL && dir == DIR_UP && floor == top)
            ok = 1'b0;
        if (in_out == CALL_HALL && dir == DIR_DOWN && floor == 0)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stable-level debounce counter and press pulse.
// A press is a one-cycle pulse on an accepted 0->1 change of the level.
module button_debouncer
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Synchronise, count differing cycles, flip level and emit press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_request_conditioner.sv
// Debounced buttons -> pending call flags -> arbiter -> request FIFO.
// Optional macro REQ_DEDUP_EN drops duplicate requests silently.
module call_request_conditioner
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int FLOOR_W         = elevator_pkg::FLOOR_W,
    parameter int TOP_FLOOR       = elevator_pkg::TOP_FLOOR,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               button_up,
    input  logic               button_down,
    input  logic               button_in,
    input  logic [FLOOR_W-1:0] sw_call_floor,
    input  logic [FLOOR_W-1:0] sw_in_floor,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [FLOOR_W-1:0] req_floor,
    output logic               req_in_out,
    output logic               req_dir,
    output logic               drop_pulse
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [FLOOR_W-1:0] floor;
        logic               in_out;
        logic               dir;
    } rec_t;

    logic press_in;
    logic press_up;
    logic press_down;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_in (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (button_in),
        .press  (press_in)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (button_up),
        .press  (press_up)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (button_down),
        .press  (press_down)
    );

    logic               pend_in;
    logic               pend_up;
    logic               pend_down;
    logic [FLOOR_W-1:0] flr_in;
    logic [FLOOR_W-1:0] flr_up;
    logic [FLOOR_W-1:0] flr_down;

    rec_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    rec_t rec_in;
    rec_t rec_up;
    rec_t rec_down;
    rec_t new_in;
    rec_t new_up;
    rec_t new_down;

    assign rec_in   = '{floor: flr_in,        in_out: CALL_IN,   dir: DIR_DOWN};
    assign rec_up   = '{floor: flr_up,        in_out: CALL_HALL, dir: DIR_UP};
    assign rec_down = '{floor: flr_down,      in_out: CALL_HALL, dir: DIR_DOWN};
    assign new_in   = '{floor: sw_in_floor,   in_out: CALL_IN,   dir: DIR_DOWN};
    assign new_up   = '{floor: sw_call_floor, in_out: CALL_HALL, dir: DIR_UP};
    assign new_down = '{floor: sw_call_floor, in_out: CALL_HALL, dir: DIR_DOWN};

    logic ok_in;
    logic ok_up;
    logic ok_down;

    assign ok_in   = call_legal(int'(sw_in_floor), TOP_FLOOR, CALL_IN, DIR_DOWN);
    assign ok_up   = call_legal(int'(sw_call_floor), TOP_FLOOR, CALL_HALL, DIR_UP);
    assign ok_down = call_legal(int'(sw_call_floor), TOP_FLOOR, CALL_HALL, DIR_DOWN);

    logic dup_in;
    logic dup_up;
    logic dup_down;

`ifdef REQ_DEDUP_EN
    // Match new presses against pending flags and live FIFO entries.
    always_comb begin
        logic [PTR_W-1:0] idx;
        dup_in   = pend_in && (rec_in == new_in);
        dup_up   = pend_up && (rec_up == new_up);
        dup_down = pend_down && (rec_down == new_down);
        idx      = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if (mem[idx] == new_in)
                    dup_in = 1'b1;
                if (mem[idx] == new_up)
                    dup_up = 1'b1;
                if (mem[idx] == new_down)
                    dup_down = 1'b1;
            end
        end
    end
`else
    assign dup_in   = 1'b0;
    assign dup_up   = 1'b0;
    assign dup_down = 1'b0;
`endif

    logic acc_in;
    logic acc_up;
    logic acc_down;
    logic drop_any;

    assign acc_in   = press_in && !dup_in && ok_in && !pend_in;
    assign acc_up   = press_up && !dup_up && ok_up && !pend_up;
    assign acc_down = press_down && !dup_down && ok_down && !pend_down;

    assign drop_any = (press_in && !dup_in && (!ok_in || pend_in))
                   || (press_up && !dup_up && (!ok_up || pend_up))
                   || (press_down && !dup_down && (!ok_down || pend_down));

    logic pop;
    logic full;
    logic push;
    logic clr_in;
    logic clr_up;
    logic clr_down;
    rec_t pick;

    assign pop  = req_valid && req_ready;
    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign push = (pend_in || pend_up || pend_down) && (!full || pop);

    // Fixed priority: car call, then hall up, then hall down.
    always_comb begin
        pick     = rec_down;
        clr_in   = 1'b0;
        clr_up   = 1'b0;
        clr_down = 1'b0;
        if (pend_in) begin
            pick   = rec_in;
            clr_in = push;
        end else if (pend_up) begin
            pick   = rec_up;
            clr_up = push;
        end else if (pend_down) begin
            pick     = rec_down;
            clr_down = push;
        end
    end

    // Capture accepted presses and retire the flag that was pushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_in    <= 1'b0;
            pend_up    <= 1'b0;
            pend_down  <= 1'b0;
            flr_in     <= '0;
            flr_up     <= '0;
            flr_down   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop_any;
            if (clr_in)
                pend_in <= 1'b0;
            if (clr_up)
                pend_up <= 1'b0;
            if (clr_down)
                pend_down <= 1'b0;
            if (acc_in) begin
                pend_in <= 1'b1;
                flr_in  <= sw_in_floor;
            end
            if (acc_up) begin
                pend_up <= 1'b1;
                flr_up  <= sw_call_floor;
            end
            if (acc_down) begin
                pend_down <= 1'b1;
                flr_down  <= sw_call_floor;
            end
        end
    end

    rec_t             mem_n [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_n;
    logic [PTR_W-1:0] wr_n;
    logic [CNT_W-1:0] count_n;
    rec_t             head_n;

    // Next FIFO state; the head is precomputed so outputs are registered.
    always_comb begin
        mem_n   = mem;
        rd_n    = rd_ptr;
        wr_n    = wr_ptr;
        count_n = count;
        if (pop)
            rd_n = rd_ptr + 1'b1;
        if (push) begin
            mem_n[wr_ptr] = pick;
            wr_n          = wr_ptr + 1'b1;
        end
        if (push && !pop)
            count_n = count + 1'b1;
        else if (pop && !push)
            count_n = count - 1'b1;
        head_n = (count_n != '0) ? mem_n[rd_n] : '0;
    end

    // FIFO storage, pointers and registered head outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            req_valid  <= 1'b0;
            req_floor  <= '0;
            req_in_out <= 1'b0;
            req_dir    <= 1'b0;
        end else begin
            mem        <= mem_n;
            rd_ptr     <= rd_n;
            wr_ptr     <= wr_n;
            count      <= count_n;
            req_valid  <= (count_n != '0);
            req_floor  <= head_n.floor;
            req_in_out <= head_n.in_out;
            req_dir    <= head_n.dir;
        end
    end

endmodule

// File: tb/tb_call_request_conditioner.sv
// Directed bench for call_request_conditioner with DEBOUNCE_CYCLES=4.
// Expected values are hand-computed; REQ_DEDUP_EN selects dedup expectations.
module tb_call_request_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       button_up;
    logic       button_down;
    logic       button_in;
    logic [2:0] sw_call_floor;
    logic [2:0] sw_in_floor;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_floor;
    logic       req_in_out;
    logic       req_dir;
    logic       drop_pulse;

    int total = 0;
    int bad   = 0;
    int drops = 0;

    call_request_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .FLOOR_W        (3),
        .TOP_FLOOR      (7),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .button_up    (button_up),
        .button_down  (button_down),
        .button_in    (button_in),
        .sw_call_floor(sw_call_floor),
        .sw_in_floor  (sw_in_floor),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_floor    (req_floor),
        .req_in_out   (req_in_out),
        .req_dir      (req_dir),
        .drop_pulse   (drop_pulse)
    );

    always #5 clk = ~clk;

    // Count drop pulses away from the active edge.
    always @(negedge clk)
        if (drop_pulse === 1'b1)
            drops++;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] head();
        return {26'd0, req_valid, req_floor, req_in_out, req_dir};
    endfunction

    task automatic press(input int src, input logic [2:0] fl);
        case (src)
            0: begin sw_in_floor = fl; button_in = 1'b1; end
            1: begin sw_call_floor = fl; button_up = 1'b1; end
            default: begin sw_call_floor = fl; button_down = 1'b1; end
        endcase
        step(10);
        button_in   = 1'b0;
        button_up   = 1'b0;
        button_down = 1'b0;
        step(8);
    endtask

    task automatic drain(output int n);
        n = 0;
        req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (req_valid)
                n++;
            step(1);
        end
        req_ready = 1'b0;
    endtask

    initial begin
        int d0;
        int seen;
        int n;

        reset_n       = 1'b0;
        button_up     = 1'b0;
        button_down   = 1'b0;
        button_in     = 1'b0;
        sw_call_floor = 3'd0;
        sw_in_floor   = 3'd0;
        req_ready     = 1'b0;

        // Reset held while buttons toggle.
        for (int i = 0; i < 6; i++) begin
            button_up   = i[0];
            button_down = ~i[0];
            button_in   = i[1];
            step(1);
        end
        chk("reset_outputs", {head(), 1'b0, drop_pulse}, 32'd0);
        button_up   = 1'b0;
        button_down = 1'b0;
        button_in   = 1'b0;
        reset_n     = 1'b1;
        step(12);
        chk("reset_release_idle", req_valid, 32'd0);

        // Glitchy car button then steady press at floor 5.
        req_ready   = 1'b1;
        sw_in_floor = 3'd5;
        button_in = 1'b1; step(1);
        button_in = 1'b0; step(1);
        button_in = 1'b1; step(1);
        button_in = 1'b0; step(1);
        button_in = 1'b1;
        step(7);
        chk("bounce_not_yet", req_valid, 32'd0);
        step(1);
        chk("bounce_head", head(), {26'd0, 1'b1, 3'd5, 1'b1, 1'b0});
        step(1);
        chk("bounce_popped", req_valid, 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (req_valid) seen++;
        end
        chk("hold_single", seen, 32'd0);
        button_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (req_valid) seen++;
        end
        chk("release_none", seen, 32'd0);

        // Simultaneous car and hall-up press.
        req_ready     = 1'b0;
        d0            = drops;
        sw_call_floor = 3'd2;
        sw_in_floor   = 3'd6;
        button_up     = 1'b1;
        button_in     = 1'b1;
        step(10);
        button_up = 1'b0;
        button_in = 1'b0;
        step(8);
        chk("prio_first", head(), {26'd0, 1'b1, 3'd6, 1'b1, 1'b0});
        req_ready = 1'b1; step(1); req_ready = 1'b0;
        chk("prio_second", head(), {26'd0, 1'b1, 3'd2, 1'b0, 1'b1});
        req_ready = 1'b1; step(1); req_ready = 1'b0;
        chk("prio_empty", req_valid, 32'd0);
        chk("prio_no_drop", drops - d0, 32'd0);

        // Illegal hall calls.
        d0 = drops;
        press(2, 3'd0);
        chk("down_floor0_drop", drops - d0, 32'd1);
        chk("down_floor0_empty", req_valid, 32'd0);
        press(1, 3'd7);
        chk("up_top_drop", drops - d0, 32'd2);
        chk("up_top_empty", req_valid, 32'd0);

        // Fill the FIFO, fifth request waits pending.
        d0 = drops;
        press(0, 3'd1);
        press(0, 3'd2);
        press(0, 3'd3);
        press(0, 3'd4);
        press(1, 3'd5);
        chk("full_head", head(), {26'd0, 1'b1, 3'd1, 1'b1, 1'b0});
        chk("full_no_drop", drops - d0, 32'd0);
        req_ready = 1'b1;
        step(1);
        chk("drain_1", head(), {26'd0, 1'b1, 3'd2, 1'b1, 1'b0});
        step(1);
        chk("drain_2", head(), {26'd0, 1'b1, 3'd3, 1'b1, 1'b0});
        step(1);
        chk("drain_3", head(), {26'd0, 1'b1, 3'd4, 1'b1, 1'b0});
        step(1);
        chk("drain_4", head(), {26'd0, 1'b1, 3'd5, 1'b0, 1'b1});
        step(1);
        chk("drain_empty", req_valid, 32'd0);
        req_ready = 1'b0;

        // Full plus one pop and one push keeps four entries.
        press(0, 3'd1);
        press(0, 3'd2);
        press(0, 3'd3);
        press(0, 3'd4);
        press(1, 3'd5);
        req_ready = 1'b1; step(1); req_ready = 1'b0;
        chk("swap_head", head(), {26'd0, 1'b1, 3'd2, 1'b1, 1'b0});
        drain(n);
        chk("swap_count", n, 32'd4);

        // Reset mid-operation clears the queue.
        press(0, 3'd3);
        chk("mid_queued", req_valid, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_clear", {head(), 1'b0, drop_pulse}, 32'd0);
        step(1);
        reset_n = 1'b1;
        step(12);
        chk("mid_reset_idle", req_valid, 32'd0);

        // Two identical hall-up presses at floor 3.
        d0 = drops;
        press(1, 3'd3);
        press(1, 3'd3);
        chk("dup_no_drop", drops - d0, 32'd0);
        drain(n);
`ifdef REQ_DEDUP_EN
        chk("dup_count", n, 32'd1);
`else
        chk("dup_count", n, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
